// File: rtl/issue_regread_pkg.sv
// Shared types and constants for the issue-queue register-read stage.
package issue_regread_pkg;

    localparam int unsigned IWD       = 4;
    localparam int unsigned WBW       = 4;
    localparam int unsigned XLEN      = 64;
    localparam int unsigned PREG_W    = 16;
    localparam int unsigned OPID_W    = 16;
    localparam int unsigned OPID_VLD  = 15;

    // Physical register 0 is hardwired to zero.
    localparam logic [PREG_W-1:0] PREG_ZERO = 16'd0;

    // Issued operation as delivered by the issue queue.
    typedef struct packed {
        logic [OPID_W-1:0]           opid;
        logic [1:0][PREG_W-1:0]      prsa;
        logic [1:0]                  prsb;
        logic [PREG_W-1:0]           prd;
    } iss_bundle_t;

    // Captured source operand: value plus validity.
    typedef struct packed {
        logic [XLEN-1:0] value;
        logic            ok;
    } rr_opnd_t;

    // Per-lane pipeline register occupancy.
    typedef enum logic {
        LANE_EMPTY = 1'b0,
        LANE_FULL  = 1'b1
    } lane_state_e;

endpackage

// File: rtl/issue_regread_opnd_bypass.sv
// Resolves one source operand from preg 0, the writeback ports (highest port
// wins) or the register file value.
module issue_regread_opnd_bypass
    import issue_regread_pkg::*;
#(
    parameter int unsigned wbw  = 4,
    parameter int unsigned xlen = 64
) (
    input  logic [PREG_W-1:0]           prsa,
    input  logic                        busy,
    input  logic [xlen-1:0]             rf_value,
    input  logic [wbw-1:0]              wb_valid,
    input  logic [wbw-1:0][PREG_W-1:0]  wb_prda,
    input  logic [wbw-1:0][xlen-1:0]    wb_data,
    output logic [xlen-1:0]             value_c,
    output logic                        ok_c
);

    logic            hit;
    logic [xlen-1:0] hit_data;

    // Later ports overwrite earlier matches so the highest index wins.
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int unsigned j = 0; j < wbw; j++) begin
            if (wb_valid[j] && (wb_prda[j] == prsa)) begin
                hit      = 1'b1;
                hit_data = wb_data[j];
            end
        end
    end

    always_comb begin
        value_c = rf_value;
        ok_c    = ~busy;
        if (prsa == PREG_ZERO) begin
            value_c = '0;
            ok_c    = 1'b1;
        end else if (hit) begin
            value_c = hit_data;
            ok_c    = 1'b1;
        end
    end

endmodule

// File: rtl/issue_regread.sv
// Register-read stage: accepts issued ops, reads/bypasses operands and holds
// each op in a one-entry per-lane register until its FU port takes it.
module issue_regread
    import issue_regread_pkg::*;
#(
    parameter int unsigned iwd  = 4,
    parameter int unsigned wbw  = 4,
    parameter int unsigned xlen = 64
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             redir,
    input  iss_bundle_t [iwd-1:0]            iss_bundle,
    output logic [iwd-1:0]                   issue,
    output logic [iwd-1:0][1:0][PREG_W-1:0]  rf_raddr,
    input  logic [iwd-1:0][1:0][xlen-1:0]    rf_rdata,
    input  logic [wbw-1:0]                   wb_valid,
    input  logic [wbw-1:0][PREG_W-1:0]       wb_prda,
    input  logic [wbw-1:0][xlen-1:0]         wb_data,
    output logic [iwd-1:0]                   rr_valid,
    input  logic [iwd-1:0]                   rr_ready,
    output iss_bundle_t [iwd-1:0]            rr_bundle,
    output logic [iwd-1:0][1:0][xlen-1:0]    rr_opnd,
    output logic [iwd-1:0][1:0]              rr_opnd_ok
);

    lane_state_e [iwd-1:0]            lane_q, lane_d;
    iss_bundle_t [iwd-1:0]            bundle_d;
    logic [iwd-1:0][1:0][xlen-1:0]    opnd_d;
    logic [iwd-1:0][1:0]              ok_d;

    logic [iwd-1:0]                   acc;
    logic [iwd-1:0][1:0][xlen-1:0]    cap_val;
    logic [iwd-1:0][1:0]              cap_ok;
    logic [iwd-1:0][1:0][xlen-1:0]    snp_val;
    logic [iwd-1:0][1:0]              snp_ok;

    // Issue handshake is independent of op validity so the queue can treat it as a credit.
    for (genvar i = 0; i < int'(iwd); i++) begin : g_lane
        assign rr_valid[i] = (lane_q[i] == LANE_FULL);
        assign issue[i]    = rst & ~redir & (~rr_valid[i] | rr_ready[i]);
        assign acc[i]      = issue[i] & iss_bundle[i].opid[OPID_VLD];

        for (genvar k = 0; k < 2; k++) begin : g_opnd
            assign rf_raddr[i][k] = iss_bundle[i].prsa[k];

            issue_regread_opnd_bypass #(
                .wbw  (wbw),
                .xlen (xlen)
            ) u_cap (
                .prsa     (iss_bundle[i].prsa[k]),
                .busy     (iss_bundle[i].prsb[k]),
                .rf_value (rf_rdata[i][k]),
                .wb_valid (wb_valid),
                .wb_prda  (wb_prda),
                .wb_data  (wb_data),
                .value_c  (cap_val[i][k]),
                .ok_c     (cap_ok[i][k])
            );

            // Held operands snoop writebacks; no-match leaves the held value unchanged.
            issue_regread_opnd_bypass #(
                .wbw  (wbw),
                .xlen (xlen)
            ) u_snp (
                .prsa     (rr_bundle[i].prsa[k]),
                .busy     (1'b1),
                .rf_value (rr_opnd[i][k]),
                .wb_valid (wb_valid),
                .wb_prda  (wb_prda),
                .wb_data  (wb_data),
                .value_c  (snp_val[i][k]),
                .ok_c     (snp_ok[i][k])
            );
        end
    end

    // Next-state: flush beats accept, accept beats dequeue/snoop.
    always_comb begin
        lane_d   = lane_q;
        bundle_d = rr_bundle;
        opnd_d   = rr_opnd;
        ok_d     = rr_opnd_ok;
        for (int unsigned i = 0; i < iwd; i++) begin
            if (redir) begin
                lane_d[i] = LANE_EMPTY;
            end else if (acc[i]) begin
                lane_d[i]   = LANE_FULL;
                bundle_d[i] = iss_bundle[i];
                opnd_d[i]   = cap_val[i];
                ok_d[i]     = cap_ok[i];
            end else begin
                unique case (lane_q[i])
                    LANE_EMPTY: lane_d[i] = LANE_EMPTY;
                    LANE_FULL: begin
                        if (rr_ready[i]) begin
                            lane_d[i] = LANE_EMPTY;
                        end else begin
                            for (int unsigned k = 0; k < 2; k++) begin
                                if (!rr_opnd_ok[i][k] && snp_ok[i][k]) begin
                                    opnd_d[i][k] = snp_val[i][k];
                                    ok_d[i][k]   = 1'b1;
                                end
                            end
                        end
                    end
                    default: lane_d[i] = LANE_EMPTY;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            lane_q     <= {iwd{LANE_EMPTY}};
            rr_bundle  <= '0;
            rr_opnd    <= '0;
            rr_opnd_ok <= '0;
        end else begin
            lane_q     <= lane_d;
            rr_bundle  <= bundle_d;
            rr_opnd    <= opnd_d;
            rr_opnd_ok <= ok_d;
        end
    end

endmodule
